// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a single ALU. One
//               operation is served at a time: accept (IDLE), compute (EXEC),
//               then hold the result until the consumer takes it (RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic [2:0]      req0_sel,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    input  logic [2:0]      req1_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE:0]   rsp_out,
    output logic            rsp_id,
    output logic            busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic            r_last;      // requester served most recently
    logic            r_id;
    logic [SIZE-1:0] r_a;
    logic [SIZE-1:0] r_b;
    logic [2:0]      r_sel;
    logic            r_rsp_valid;
    logic [SIZE:0]   r_rsp_out;
    logic            r_rsp_id;

    logic            w_grant0;
    logic            w_grant1;
    logic            w_open;
    logic            w_accept;
    logic [SIZE:0]   w_result;

    // Round-robin grant: a lone requester wins, a tie goes to the one not last served
    always_comb begin
        w_grant0   = req0_valid && (!req1_valid || r_last);
        w_grant1   = req1_valid && (!req0_valid || !r_last);
        w_open     = (r_state == c_IDLE) && !rst;
        req0_ready = w_open && w_grant0;
        req1_ready = w_open && w_grant1;
        w_accept   = req0_ready || req1_ready;
    end

    // ALU on the captured operands; carry/borrow land in the top bit for add/sub
    always_comb begin
        w_result = '0;
        case (r_sel)
            3'b000:  w_result = {1'b0, r_a} + {1'b0, r_b};
            3'b001:  w_result = {1'b0, r_a} - {1'b0, r_b};
            3'b010:  w_result = {1'b0, r_a | r_b};
            3'b011:  w_result = {1'b0, r_a & r_b};
            3'b100:  w_result = {1'b0, r_a ^ r_b};
            3'b101:  w_result = {1'b0, ~(r_a | r_b)};
            3'b110:  w_result = {1'b0, ~(r_a & r_b)};
            default: w_result = {1'b0, ~(r_a ^ r_b)};
        endcase
    end

    // Transaction FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req1_ready ? req1_a   : req0_a;
                        r_b     <= req1_ready ? req1_b   : req0_b;
                        r_sel   <= req1_ready ? req1_sel : req0_sel;
                        r_id    <= req1_ready;
                        r_last  <= req1_ready;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_rsp_out <= w_result;
                    r_rsp_id  <= r_id;
                    r_state   <= c_RESP;
                end
                c_RESP: begin
                    // First RESP cycle raises valid; afterwards wait for the consumer
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_out   = r_rsp_out;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire
